sequential_multiplier: RTL
==========================

SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; Product width is 2*WIDTH.
REQ-002 The block SHALL have port CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port START  input  1  request; sampled on rising CLOCK.
REQ-005 The block SHALL have port Multiplicand  input  WIDTH  two's-complement operand A, sampled with START.
REQ-006 The block SHALL have port Multiplier  input  WIDTH  two's-complement operand B, sampled with START.
REQ-007 The block SHALL have port Product  output  2*WIDTH  registered two's-complement A*B.
REQ-008 The block SHALL have port Finish  output  1  registered; high while Product holds a completed result.
REQ-009 The block SHALL have port Busy  output  1  registered; high while a multiplication is in progress.

Function
REQ-010 The block SHALL implement states IDLE, RUN, FIX, DONE.
REQ-011 In IDLE or DONE with START=1 at a rising edge, the block SHALL:
- latch |A| and |B| as WIDTH-bit unsigned magnitudes
- latch sign = A[WIDTH-1] XOR B[WIDTH-1]
- clear the 2*WIDTH accumulator and iteration counter
- set Finish=0, Busy=1
- enter RUN.
REQ-012 Magnitude of the most negative operand (-2^(WIDTH-1)) SHALL be 2^(WIDTH-1) unsigned, with no overflow or saturation.
REQ-013 Each RUN cycle SHALL:
- add |A| into the accumulator upper half when the current multiplier LSB is 1, keeping the carry
- shift accumulator and multiplier right by one
- increment the counter.
REQ-014 After exactly WIDTH RUN cycles, the block SHALL enter FIX.
REQ-015 In FIX the block SHALL:
- write Product = sign ? two's-complement negation of accumulator : accumulator
- set Finish=1, Busy=0
- enter DONE.
REQ-016 Latency SHALL be WIDTH+2 rising edges: the START edge plus WIDTH RUN edges plus the FIX edge; Finish is first seen high after the FIX edge (edge k+WIDTH+1 for a START edge k).
REQ-017 Product SHALL keep its previous value throughout RUN and change only in FIX.
REQ-018 START during RUN or FIX SHALL be ignored, with no restart and no operand re-sampling.
REQ-019 In DONE, Finish and Product SHALL hold indefinitely while START=0.
REQ-020 START=1 in DONE SHALL start a new operation on that edge and drop Finish (back-to-back operation).
REQ-021 START held high continuously SHALL produce one multiplication per WIDTH+2 cycles.
REQ-022 A zero operand SHALL still take full latency and yield Product=0, never negative zero or a sign artefact.
REQ-023 Product SHALL be exact for all operand pairs; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) SHALL fit without overflow.

Reset
REQ-024 RESET_N=0 SHALL immediately, without waiting for CLOCK, force:
- state IDLE, Product=0, Finish=0, Busy=0
- accumulator, counter and sign cleared.
REQ-025 Reset asserted mid-RUN or mid-FIX SHALL abort the operation; no partial result SHALL appear on Product.
REQ-026 After RESET_N deasserts, the first rising edge with START=1 SHALL begin a normal operation.

Verification
REQ-027 START with A=7, B=-3 -> Busy=1 for 33 cycles, then Product=-21 (0xFFFFFFFFFFFFFFEB), Finish=1, Busy=0.
REQ-028 A=0x80000000, B=0x80000000 -> Product=0x4000000000000000; A=0x80000000, B=1 -> Product=0xFFFFFFFF80000000.
REQ-029 A=0, B=-5 -> Product=0 after 34 edges; A=0x7FFFFFFF, B=0x7FFFFFFF -> Product=0x3FFFFFFF00000001.
REQ-030 START pulsed again 10 cycles into RUN with new operands -> ignored; first result is unchanged and the latency is still 34 edges.
REQ-031 START held high with A=2,B=3 then A=-4,B=5 -> Product=6, then one cycle later Finish drops, then after latency Product=-20; Product stays 6 until FIX.
REQ-032 RESET_N pulsed low mid-RUN, asynchronous to CLOCK -> Product=0, Finish=0, Busy=0 at once; a fresh START then completes correctly.

Source files
------------

// File: rtl/sequential_multiplier.sv
// Signed shift-add multiplier: multiplies operand magnitudes over WIDTH cycles,
// then applies the result sign in a single fix-up cycle.
module sequential_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Finish,
  output logic               Busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     partial;

  // Operand magnitudes; -2^(WIDTH-1) maps onto 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    abs_a = Multiplicand[WIDTH-1] ? ({WIDTH{1'b0}} - Multiplicand) : Multiplicand;
    abs_b = Multiplier[WIDTH-1]   ? ({WIDTH{1'b0}} - Multiplier)   : Multiplier;
  end

  // Upper-half add with the carry kept as an extra bit for the right shift.
  always_comb begin
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (mplier_q[0]) begin
      partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sign_d    = sign_q;
    product_d = product_q;
    finish_d  = finish_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          sign_d   = Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1];
          acc_d    = '0;
          count_d  = '0;
          finish_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = {partial, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Negating a zero accumulator yields zero, so no negative-zero case exists.
        product_d = sign_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        finish_d  = 1'b1;
        busy_d    = 1'b0;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear; reset discards any partial result.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
    end
  end

  assign Product = product_q;
  assign Finish  = finish_q;
  assign Busy    = busy_q;

endmodule
